traffic_light_fsm: RTL and testbench
====================================

# traffic_light_fsm

Main controller of the highway/farm-road traffic light. It sequences the two road signals through green, yellow and red. It restarts the external short timer (yellow interval) and long timer (minimum green / maximum farm green) on every state entry, and consumes their terminal-count flags. It also synchronises the asynchronous farm-road car sensor before using it.

## Interface
Parameters:
- none; all dwell times come from the external timers.

Ports:
- clk  input  1  system clock, all logic on rising edge
- arst  input  1  reset, asynchronous, active-high; clock clk
- car_raw  input  1  farm-road vehicle sensor, asynchronous to clk, level, high = car present
- TS_out  input  1  short-timer terminal flag; count 7 reached, 8 cycles after restart
- TL_out  input  1  long-timer terminal flag; same contract as TS_out with a longer terminal count
- TS_start  output  1  registered one-cycle restart pulse to the short timer
- TL_start  output  1  registered one-cycle restart pulse to the long timer
- hwy_light  output  2  highway signal: 2'b00 green, 2'b01 yellow, 2'b10 red (2'b11 never driven)
- farm_light  output  2  farm-road signal, same encoding
- state  output  2  current state for debug: HG=0, HY=1, FG=2, FY=3

## Operation
- **Sensor synchroniser**
  - car_raw passes through a 2-flop synchroniser to give car.
  - Only car is used by the FSM.
  - Both flops reset to 0.
- **State HG**
  - Highway green, farm red.
  - Go to HY when car && TL_out.
- **State HY**
  - Highway yellow, farm red.
  - Go to FG when TS_out.
- **State FG**
  - Highway red, farm green.
  - Go to FY when !car || TL_out.
- **State FY**
  - Highway red, farm yellow.
  - Go to HG when TS_out.
- **Timer restarts**
  - On every transition, the restart pulse is registered together with the new state.
  - Entering HG or FG pulses TL_start; entering HY or FY pulses TS_start.
  - Each pulse lasts exactly one cycle; it is never asserted with no transition.
- **First cycle of a state (guard cycle)**
  - This is the cycle in which the state's *_start is high.
  - All transitions are blocked, because the timer flag may still reflect the previous count.
  - From the second cycle on, the conditions above are evaluated every cycle.
- **Spurious timer flags**
  - The timers free-run and re-flag every terminal-count period if not restarted.
  - A flag is honoured only in the state that expects it: TL_out in HG/FG, TS_out in HY/FY.
  - In any other state the flag is ignored.
- **Light outputs**
  - hwy_light and farm_light are registered and decoded from the next state.
  - They change on the same edge as state.
- **Safety invariant**
  - At least one of hwy_light and farm_light is 2'b10 in every cycle.
- **Simultaneous conditions**
  - In FG, !car and TL_out together give one transition to FY.
  - In HG, car falling in the same cycle TL_out is seen means no transition.
- **Reset**
  - arst at any time, including mid-sequence, immediately forces:
    - state = HG
    - hwy_light = 2'b00, farm_light = 2'b10
    - TS_start = 0, TL_start = 1
    - synchroniser flops = 0
  - The first cycle after reset release is therefore an HG guard cycle.
  - TL_start drops at the first clk edge after release.

## Timing
- **car latency:** car follows car_raw after 2 edges; FSM reaction to a car_raw change is ≥3 edges.
- **Yellow dwell (HY, FY):**
  - Entry at edge E; the short timer clears at E+1.
  - TS_out is high in the cycle after E+8; exit is at E+9.
  - Dwell is exactly 9 cycles.
- **Long-timer dwell:**
  - For a long timer with terminal count N, TL_out first qualifies N+1 cycles after entry.
  - The earliest HG or FG exit is at entry+N+2.
  - Bench model uses N=15, so 17 cycles.
- **Single step per edge:** state changes at most once per clock edge; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:**
  - Assert arst mid-cycle with clk running -> immediately state=0, hwy=00, farm=10, TS_start=0, TL_start=1.
  - Release -> TL_start=0 after 1 edge.
- **No car:** car_raw=0 for 200 cycles with the long timer re-flagging every 16 cycles -> state stays HG and TS_start never pulses.
- **Full cycle:** car_raw=1 from reset release -> expected sequence:
  - HG exits at edge 17.
  - HY lasts 9 cycles with one TS_start pulse.
  - FG lasts 17 cycles (long-timer cap), then FY lasts 9 cycles, then back to HG with a TL_start pulse.
- **Car leaves:** in FG cycle 5, drop car_raw -> FY entered 3 edges later, then HG 9 cycles after that.
- **Stale flag:** force TS_out=1 during the HY guard cycle and TL_out=1 during the FG guard cycle -> no transition, and the state holds for the full dwell.
- **Reset mid-FY and invariant:**
  - arst during FY -> immediate HG lights, no glitch through yellow.
  - Assertion across all tests: never both lights != 2'b10.

Source files
------------

// File: rtl/traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// traffic_light_fsm
//
// Main controller for the highway / farm-road intersection. It steps the two
// road signals through green -> yellow -> red. It restarts the external short
// timer (yellow interval) and long timer (minimum green / maximum farm green)
// on every state entry, and reacts to their terminal-count flags.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   arst       : asynchronous, active-high reset
//   car_raw    : farm-road car sensor, asynchronous level (1 = car present)
//   TS_out     : short-timer terminal flag
//   TL_out     : long-timer terminal flag
//   TS_start   : registered one-cycle restart pulse to the short timer
//   TL_start   : registered one-cycle restart pulse to the long timer
//   hwy_light  : highway signal   (00 green, 01 yellow, 10 red)
//   farm_light : farm-road signal (same encoding)
//   state      : current state for debug (HG=0, HY=1, FG=2, FY=3)
// ---------------------------------------------------------------------------
module traffic_light_fsm (
  input  logic       clk,
  input  logic       arst,
  input  logic       car_raw,
  input  logic       TS_out,
  input  logic       TL_out,
  output logic       TS_start,
  output logic       TL_start,
  output logic [1:0] hwy_light,
  output logic [1:0] farm_light,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    HG = 2'd0,  // highway green, farm red
    HY = 2'd1,  // highway yellow, farm red
    FG = 2'd2,  // highway red, farm green
    FY = 2'd3   // highway red, farm yellow
  } state_t;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  state_t     state_reg, state_next;
  logic       car_meta_reg, car_reg;
  logic       ts_start_reg, ts_start_next;
  logic       tl_start_reg, tl_start_next;
  logic [1:0] hwy_reg, hwy_next;
  logic [1:0] farm_reg, farm_next;
  logic       guard;

  // Two-flop synchroniser for the sensor; only car_reg reaches the FSM.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      car_meta_reg <= 1'b0;
      car_reg      <= 1'b0;
    end else begin
      car_meta_reg <= car_raw;
      car_reg      <= car_meta_reg;
    end
  end

  // State, timer restart pulses and lights are all registered together, so
  // every output changes on the same edge as the state. Reset lands in the
  // HG guard cycle: TL_start is held high so the long timer restarts.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg    <= HG;
      ts_start_reg <= 1'b0;
      tl_start_reg <= 1'b1;
      hwy_reg      <= LIGHT_GREEN;
      farm_reg     <= LIGHT_RED;
    end else begin
      state_reg    <= state_next;
      ts_start_reg <= ts_start_next;
      tl_start_reg <= tl_start_next;
      hwy_reg      <= hwy_next;
      farm_reg     <= farm_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ts_start_next = 1'b0;
    tl_start_next = 1'b0;
    hwy_next      = LIGHT_RED;
    farm_next     = LIGHT_RED;

    // A start pulse is high only in the first cycle of a state. In that cycle
    // the timer has not yet cleared, so its flag may still reflect the old
    // count and must not be trusted.
    guard = ts_start_reg | tl_start_reg;

    if (!guard) begin
      unique case (state_reg)
        HG: if (car_reg && TL_out)  state_next = HY;
        HY: if (TS_out)             state_next = FG;
        FG: if (!car_reg || TL_out) state_next = FY;
        FY: if (TS_out)             state_next = HG;
        default:                    state_next = HG;
      endcase
    end

    // Restart pulses fire only when the state actually changes.
    if (state_next != state_reg) begin
      ts_start_next = (state_next == HY) || (state_next == FY);
      tl_start_next = (state_next == HG) || (state_next == FG);
    end

    // Lights are decoded from the next state; one side is always red.
    unique case (state_next)
      HG: begin hwy_next = LIGHT_GREEN;  farm_next = LIGHT_RED;    end
      HY: begin hwy_next = LIGHT_YELLOW; farm_next = LIGHT_RED;    end
      FG: begin hwy_next = LIGHT_RED;    farm_next = LIGHT_GREEN;  end
      FY: begin hwy_next = LIGHT_RED;    farm_next = LIGHT_YELLOW; end
      default: begin hwy_next = LIGHT_RED; farm_next = LIGHT_RED;  end
    endcase
  end

  assign state      = state_reg;
  assign TS_start   = ts_start_reg;
  assign TL_start   = tl_start_reg;
  assign hwy_light  = hwy_reg;
  assign farm_light = farm_reg;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_fsm
//
// Directed bench for traffic_light_fsm. Simple free-running timer models
// (short: terminal 7, long: terminal 15) are restarted by the DUT pulses.
// Edges are numbered from reset release, and expected values are hand-derived
// at fixed edge numbers.
// ---------------------------------------------------------------------------
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       car_raw = 1'b0;
  logic       TS_out, TL_out;
  logic       TS_start, TL_start;
  logic [1:0] hwy_light, farm_light, state;

  logic       ts_force = 1'b0;
  logic       tl_force = 1'b0;
  logic [2:0] ts_cnt = 3'd0;
  logic [3:0] tl_cnt = 4'd0;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int ts_pulses = 0;
  int tl_flags  = 0;
  bit inv_en    = 1'b0;

  localparam logic [1:0] S_HG = 2'd0, S_HY = 2'd1, S_FG = 2'd2, S_FY = 2'd3;
  localparam logic [1:0] GRN = 2'b00, YEL = 2'b01, RED = 2'b10;

  traffic_light_fsm dut (
    .clk        (clk),
    .arst       (arst),
    .car_raw    (car_raw),
    .TS_out     (TS_out),
    .TL_out     (TL_out),
    .TS_start   (TS_start),
    .TL_start   (TL_start),
    .hwy_light  (hwy_light),
    .farm_light (farm_light),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Timer models: a restart pulse clears the count on the next edge;
  // otherwise the count free-runs and wraps, re-flagging every period.
  always @(posedge clk) begin
    if (TS_start === 1'b1) ts_cnt <= 3'd0;
    else                   ts_cnt <= ts_cnt + 3'd1;
    if (TL_start === 1'b1) tl_cnt <= 4'd0;
    else                   tl_cnt <= tl_cnt + 4'd1;
  end

  assign TS_out = (ts_cnt == 3'd7)  | ts_force;
  assign TL_out = (tl_cnt == 4'd15) | tl_force;

  always @(posedge clk) begin
    if (TS_start === 1'b1) ts_pulses++;
    if (TL_out) tl_flags++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_n, got, exp);
    end
  endtask

  // Safety invariant: at least one road shows red in every cycle.
  always @(negedge clk) begin
    if (inv_en)
      check("safety", 32'((hwy_light == RED) || (farm_light == RED)), 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic goto_edge(input int k);
    while (edge_n < k) tick();
  endtask

  task automatic check_st(input string tag, input logic [1:0] st, input logic [1:0] hw,
                          input logic [1:0] fm, input logic ts, input logic tl);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_hwy"},   32'(hwy_light), 32'(hw));
    check({tag, "_farm"},  32'(farm_light), 32'(fm));
    check({tag, "_ts"},    32'(TS_start), 32'(ts));
    check({tag, "_tl"},    32'(TL_start), 32'(tl));
  endtask

  task automatic release_reset();
    @(negedge clk);
    arst   = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    // ---------------- reset asserted mid-cycle with clk running -------------
    @(posedge clk); @(posedge clk);
    #3 arst = 1'b1;
    #1;
    check_st("reset", S_HG, GRN, RED, 1'b0, 1'b1);
    inv_en = 1'b1;
    repeat (2) @(posedge clk);
    release_reset();
    tick();
    check_st("rel1", S_HG, GRN, RED, 1'b0, 1'b0);

    // ---------------- no car: stays HG despite re-flagging long timer -------
    ts_pulses = 0;
    tl_flags  = 0;
    begin
      bit left_hg = 1'b0;
      for (int i = 0; i < 200; i++) begin
        tick();
        if (state != S_HG) left_hg = 1'b1;
      end
      check("nocar_left_hg", 32'(left_hg), 32'd0);
    end
    check("nocar_state", 32'(state), 32'(S_HG));
    check("nocar_ts_pulses", 32'(ts_pulses), 32'd0);
    check("nocar_tl_reflag", 32'(tl_flags >= 12), 32'd1);

    // ---------------- full cycle with car present from release --------------
    arst = 1'b1;
    car_raw = 1'b1;
    repeat (2) @(posedge clk);
    release_reset();
    ts_pulses = 0;
    goto_edge(16); check_st("hg_e16", S_HG, GRN, RED, 1'b0, 1'b0);
    goto_edge(17); check_st("hy_e17", S_HY, YEL, RED, 1'b1, 1'b0);
    goto_edge(18); check_st("hy_e18", S_HY, YEL, RED, 1'b0, 1'b0);
    goto_edge(25); check("hy_e25_state", 32'(state), 32'(S_HY));
    goto_edge(26); check_st("fg_e26", S_FG, RED, GRN, 1'b0, 1'b1);
    check("hy_ts_pulses", 32'(ts_pulses), 32'd1);
    goto_edge(42); check("fg_e42_state", 32'(state), 32'(S_FG));
    goto_edge(43); check_st("fy_e43", S_FY, RED, YEL, 1'b1, 1'b0);
    goto_edge(51); check("fy_e51_state", 32'(state), 32'(S_FY));
    goto_edge(52); check_st("hg_e52", S_HG, GRN, RED, 1'b0, 1'b1);

    // ---------------- car leaves during FG ----------------------------------
    goto_edge(69); check_st("hy_e69", S_HY, YEL, RED, 1'b1, 1'b0);
    goto_edge(77); check("hy_e77_state", 32'(state), 32'(S_HY));
    goto_edge(78); check_st("fg_e78", S_FG, RED, GRN, 1'b0, 1'b1);
    goto_edge(82); car_raw = 1'b0;          // FG cycle 5
    goto_edge(84); check("fg_e84_state", 32'(state), 32'(S_FG));
    goto_edge(85); check_st("fy_e85", S_FY, RED, YEL, 1'b1, 1'b0);
    goto_edge(93); check("fy_e93_state", 32'(state), 32'(S_FY));
    goto_edge(94); check_st("hg_e94", S_HG, GRN, RED, 1'b0, 1'b1);

    // ---------------- stale flags in guard cycles ---------------------------
    car_raw = 1'b1;
    goto_edge(110); check("hg_e110_state", 32'(state), 32'(S_HG));
    goto_edge(111); check_st("hy_e111", S_HY, YEL, RED, 1'b1, 1'b0);
    ts_force = 1'b1;                        // HY guard cycle
    goto_edge(112); ts_force = 1'b0;
    check("stale_ts_state", 32'(state), 32'(S_HY));
    goto_edge(119); check("hy_e119_state", 32'(state), 32'(S_HY));
    goto_edge(120); check_st("fg_e120", S_FG, RED, GRN, 1'b0, 1'b1);
    tl_force = 1'b1;                        // FG guard cycle
    goto_edge(121); tl_force = 1'b0;
    check("stale_tl_state", 32'(state), 32'(S_FG));
    goto_edge(136); check("fg_e136_state", 32'(state), 32'(S_FG));
    goto_edge(137); check_st("fy_e137", S_FY, RED, YEL, 1'b1, 1'b0);

    // ---------------- reset in the middle of FY -----------------------------
    goto_edge(140);
    #3 arst = 1'b1;
    #1;
    check_st("rst_fy", S_HG, GRN, RED, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    release_reset();
    tick();
    check_st("rst_fy_rel", S_HG, GRN, RED, 1'b0, 1'b0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
